// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline controller for the five-stage core.
//
// Owns the fetch PC and the instruction ROM enable. It turns per-stage stall
// requests into a stall/bubble vector and runs flush and halt through a
// four-state FSM. It also keeps a saturating stall-cycle counter and a hang
// watchdog.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   stallreq   in   [STAGES]  per-stage stall request (bit 0 = IF)
//   flush_req  in   flush request (exception / redirect)
//   flush_pc   in   [PC_W]    redirect target, taken with flush_req
//   halt_req   in   stop fetching
//   resume     in   leave HALT
//   cnt_clr    in   synchronous clear of stall_cnt
//   ce         out  instruction ROM enable (registered)
//   pc         out  [PC_W]    fetch address (registered)
//   stall      out  [STAGES]  per-stage hold (combinational)
//   bubble     out  [STAGES]  per-stage NOP insertion (combinational)
//   flush      out  clear all pipeline registers (decode of state)
//   state      out  [2]       IDLE=0, RUN=1, FLUSH=2, HALT=3
//   stall_cnt  out  [CNT_W]   saturating count of stalled RUN cycles
//   hang       out  watchdog flag (registered)
module pipe_ctrl #(
    parameter int unsigned         STAGES   = 5,
    parameter int unsigned         PC_W     = 32,
    parameter logic [PC_W-1:0]     RESET_PC = '0,
    parameter logic [PC_W-1:0]     PC_INC   = PC_W'(4),
    parameter int unsigned         CNT_W    = 32,
    parameter int unsigned         TIMEOUT  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] stallreq,
    input  logic              flush_req,
    input  logic [PC_W-1:0]   flush_pc,
    input  logic              halt_req,
    input  logic              resume,
    input  logic              cnt_clr,
    output logic              ce,
    output logic [PC_W-1:0]   pc,
    output logic [STAGES-1:0] stall,
    output logic [STAGES-1:0] bubble,
    output logic              flush,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic              hang
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam int unsigned     RL_W   = $clog2(TIMEOUT + 1);
    localparam logic [RL_W-1:0] RL_MAX = RL_W'(TIMEOUT);

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [RL_W-1:0] sat_inc_rl(input logic [RL_W-1:0] v);
        return (v == RL_MAX) ? v : v + 1'b1;
    endfunction

    state_t            state_q, state_d;
    logic              ce_q, ce_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RL_W-1:0]   run_len_q, run_len_d;
    logic              hang_q, hang_d;

    logic [STAGES-1:0] req_mask;
    logic [STAGES-1:0] req_bubble;
    logic              seen;
    logic              any_req;
    logic              run_stall;

    // Thermometer fill from the highest requesting stage downward: every
    // stage at or below the requester must hold. The bubble goes into the
    // first stage above the held region, which is the 1->0 step of the mask.
    always_comb begin
        seen       = 1'b0;
        req_mask   = '0;
        req_bubble = '0;
        for (int j = STAGES - 1; j >= 0; j--) begin
            seen        = seen | stallreq[j];
            req_mask[j] = seen;
        end
        for (int j = 1; j < STAGES; j++) begin
            req_bubble[j] = req_mask[j-1] & ~req_mask[j];
        end
    end

    always_comb begin
        stall  = '0;
        bubble = '0;
        case (state_q)
            S_RUN: begin
                stall  = req_mask;
                bubble = req_bubble;
            end
            S_HALT:  stall = '1;
            default: ;
        endcase
    end

    assign any_req   = |stallreq;
    assign run_stall = (state_q == S_RUN) && any_req;

    always_comb begin
        state_d = state_q;
        ce_d    = ce_q;
        pc_d    = pc_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_RUN;
                ce_d    = 1'b1;
            end
            S_RUN: begin
                if (flush_req) begin
                    state_d = S_FLUSH;
                    ce_d    = 1'b1;
                    pc_d    = flush_pc;
                end else if (halt_req) begin
                    state_d = S_HALT;
                    ce_d    = 1'b0;
                end else if (!req_mask[0]) begin
                    pc_d = pc_q + PC_INC;
                end
            end
            S_FLUSH: begin
                ce_d = 1'b1;
                if (flush_req) begin
                    pc_d = flush_pc;
                end else begin
                    state_d = S_RUN;
                    pc_d    = pc_q + PC_INC;
                end
            end
            S_HALT: begin
                // A flush outranks resume; resume outranks a held halt_req.
                if (flush_req) begin
                    state_d = S_FLUSH;
                    ce_d    = 1'b1;
                    pc_d    = flush_pc;
                end else if (resume) begin
                    state_d = S_RUN;
                    ce_d    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (run_stall) begin
            cnt_d = sat_inc_cnt(cnt_q);
        end

        run_len_d = run_stall ? sat_inc_rl(run_len_q) : '0;

        hang_d = hang_q;
        if (state_d == S_FLUSH) begin
            hang_d = 1'b0;
        end else if ((state_q == S_RUN) && !any_req) begin
            hang_d = 1'b0;
        end else if (run_len_d == RL_MAX) begin
            hang_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ce_q      <= 1'b0;
            pc_q      <= RESET_PC;
            cnt_q     <= '0;
            run_len_q <= '0;
            hang_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ce_q      <= ce_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            run_len_q <= run_len_d;
            hang_q    <= hang_d;
        end
    end

    assign ce        = ce_q;
    assign pc        = pc_q;
    assign flush     = (state_q == S_FLUSH);
    assign state     = state_q;
    assign stall_cnt = cnt_q;
    assign hang      = hang_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed steps followed by a randomized phase, all
// compared against a behavioural model of the controller's rules.
module tb_pipe_ctrl;

    localparam int          STAGES   = 5;
    localparam int          PC_W     = 32;
    localparam int          CNT_W    = 2;
    localparam int          TIMEOUT  = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] PC_INC   = 32'h4;
    localparam int          CNT_MAX  = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  stallreq;
    logic        flush_req;
    logic [31:0] flush_pc;
    logic        halt_req;
    logic        resume;
    logic        cnt_clr;
    logic        ce;
    logic [31:0] pc;
    logic [4:0]  stall;
    logic [4:0]  bubble;
    logic        flush;
    logic [1:0]  state;
    logic [1:0]  stall_cnt;
    logic        hang;

    pipe_ctrl #(
        .STAGES   (STAGES),
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC),
        .PC_INC   (PC_INC),
        .CNT_W    (CNT_W),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stallreq  (stallreq),
        .flush_req (flush_req),
        .flush_pc  (flush_pc),
        .halt_req  (halt_req),
        .resume    (resume),
        .cnt_clr   (cnt_clr),
        .ce        (ce),
        .pc        (pc),
        .stall     (stall),
        .bubble    (bubble),
        .flush     (flush),
        .state     (state),
        .stall_cnt (stall_cnt),
        .hang      (hang)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: state as an int (0 IDLE, 1 RUN, 2 FLUSH, 3 HALT).
    int          m_state;
    logic [31:0] m_pc;
    logic        m_ce;
    int          m_cnt;
    int          m_run;
    logic        m_hang;

    function automatic int top_req(input logic [4:0] req);
        int k;
        k = -1;
        for (int i = 0; i < STAGES; i++) if (req[i]) k = i;
        return k;
    endfunction

    function automatic logic [4:0] exp_stall(input int st, input logic [4:0] req);
        int k;
        k = top_req(req);
        if (st == 3) return 5'b11111;
        if (st != 1 || k < 0) return 5'b0;
        return 5'((1 << (k + 1)) - 1);
    endfunction

    function automatic logic [4:0] exp_bubble(input int st, input logic [4:0] req);
        int k;
        k = top_req(req);
        if (st != 1 || k < 0 || k + 1 >= STAGES) return 5'b0;
        return 5'(1 << (k + 1));
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_pc    = RESET_PC;
        m_ce    = 1'b0;
        m_cnt   = 0;
        m_run   = 0;
        m_hang  = 1'b0;
    endtask

    task automatic model_update();
        logic sreq;
        sreq = |stallreq;
        if (rst) begin
            model_reset();
            return;
        end
        if (cnt_clr) m_cnt = 0;
        else if (m_state == 1 && sreq && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        case (m_state)
            0: begin
                m_state = 1;
                m_ce    = 1'b1;
            end
            1: begin
                m_run = sreq ? ((m_run < TIMEOUT) ? m_run + 1 : TIMEOUT) : 0;
                if (flush_req || !sreq) m_hang = 1'b0;
                else if (m_run == TIMEOUT) m_hang = 1'b1;
                if (flush_req) begin
                    m_state = 2;
                    m_pc    = flush_pc;
                end else if (halt_req) begin
                    m_state = 3;
                    m_ce    = 1'b0;
                end else if (!sreq) begin
                    m_pc = m_pc + PC_INC;
                end
            end
            2: begin
                m_run = 0;
                if (flush_req) m_pc = flush_pc;
                else begin
                    m_pc    = m_pc + PC_INC;
                    m_state = 1;
                end
            end
            default: begin
                m_run = 0;
                if (flush_req) begin
                    m_state = 2;
                    m_ce    = 1'b1;
                    m_pc    = flush_pc;
                    m_hang  = 1'b0;
                end else if (resume) begin
                    m_state = 1;
                    m_ce    = 1'b1;
                end
            end
        endcase
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ce"},        64'(ce),        64'(m_ce));
        chk({tag, ".pc"},        64'(pc),        64'(m_pc));
        chk({tag, ".state"},     64'(state),     64'(m_state));
        chk({tag, ".flush"},     64'(flush),     64'(m_state == 2));
        chk({tag, ".stall"},     64'(stall),     64'(exp_stall(m_state, stallreq)));
        chk({tag, ".bubble"},    64'(bubble),    64'(exp_bubble(m_state, stallreq)));
        chk({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(m_cnt));
        chk({tag, ".hang"},      64'(hang),      64'(m_hang));
    endtask

    // Check everything mid-cycle, then let one rising edge happen.
    task automatic step(input string tag);
        @(negedge clk);
        check_all(tag);
        @(posedge clk);
        model_update();
        #1;
    endtask

    int          burst;
    logic [31:0] held_pc;

    initial begin
        rst       = 1'b1;
        stallreq  = '0;
        flush_req = 1'b0;
        flush_pc  = '0;
        halt_req  = 1'b0;
        resume    = 1'b0;
        cnt_clr   = 1'b0;
        burst     = 0;
        model_reset();

        // Reset held for two edges, then release.
        step("reset");
        step("reset");
        rst = 1'b0;
        chk("idle_ce", 64'(ce), 64'd0);
        step("idle");
        for (int i = 0; i < 4; i++) begin
            chk("boot_pc", 64'(pc), 64'(i * 4));
            step("boot");
        end

        // Stall at stage 2 for three edges.
        stallreq = 5'b00100;
        #1;
        chk("s2_stall", 64'(stall), 64'h07);
        chk("s2_bubble", 64'(bubble), 64'h08);
        held_pc = pc;
        for (int i = 0; i < 3; i++) step("stall2");
        chk("s2_pc_frozen", 64'(pc), 64'(held_pc));
        chk("s2_cnt", 64'(stall_cnt), 64'd3);
        stallreq = 5'b00011;
        #1;
        chk("s1_stall", 64'(stall), 64'h03);
        chk("s1_bubble", 64'(bubble), 64'h04);
        step("stall1");
        chk("s1_hang_set", 64'(hang), 64'd1);
        chk("s1_cnt_sat", 64'(stall_cnt), 64'd3);
        stallreq = '0;
        step("unstall");
        chk("hang_clr", 64'(hang), 64'd0);
        cnt_clr = 1'b1;
        step("cnt_clr");
        chk("cnt_cleared", 64'(stall_cnt), 64'd0);
        cnt_clr = 1'b0;

        // Flush beats halt and stall on the same edge.
        flush_req = 1'b1;
        flush_pc  = 32'h80;
        halt_req  = 1'b1;
        stallreq  = 5'b00010;
        step("flush_pri");
        halt_req  = 1'b0;
        flush_req = 1'b0;
        chk("fl_state", 64'(state), 64'd2);
        chk("fl_flush", 64'(flush), 64'd1);
        chk("fl_stall", 64'(stall), 64'd0);
        chk("fl_pc", 64'(pc), 64'h80);
        stallreq = '0;
        step("flush_exit");
        chk("fl_run_pc", 64'(pc), 64'h84);
        chk("fl_run_state", 64'(state), 64'd1);
        flush_req = 1'b1;
        flush_pc  = 32'h100;
        step("flush_b2b");
        step("flush_b2b");
        chk("b2b_state", 64'(state), 64'd2);
        chk("b2b_pc", 64'(pc), 64'h100);
        flush_req = 1'b0;
        step("b2b_exit");

        // Halt, stay halted, resume with halt_req still high.
        halt_req = 1'b1;
        step("halt_in");
        stallreq = 5'b00001;
        #1;
        chk("h_ce", 64'(ce), 64'd0);
        chk("h_stall", 64'(stall), 64'h1f);
        chk("h_state", 64'(state), 64'd3);
        held_pc = pc;
        step("halt_hold");
        resume = 1'b1;
        step("resume");
        resume   = 1'b0;
        halt_req = 1'b0;
        stallreq = '0;
        chk("r_state", 64'(state), 64'd1);
        chk("r_ce", 64'(ce), 64'd1);
        chk("r_pc", 64'(pc), 64'(held_pc));
        halt_req = 1'b1;
        step("halt_again");
        halt_req  = 1'b0;
        flush_req = 1'b1;
        flush_pc  = 32'h200;
        step("halt_flush");
        flush_req = 1'b0;
        chk("hf_state", 64'(state), 64'd2);
        chk("hf_pc", 64'(pc), 64'h200);
        step("hf_exit");

        // Watchdog on a continuous top-stage stall.
        stallreq = 5'b10000;
        for (int i = 0; i < 3; i++) step("wd");
        chk("wd_not_yet", 64'(hang), 64'd0);
        step("wd");
        chk("wd_hang", 64'(hang), 64'd1);
        step("wd_hold");
        chk("wd_cnt_sat", 64'(stall_cnt), 64'd3);
        stallreq = '0;
        step("wd_release");
        chk("wd_clear", 64'(hang), 64'd0);

        // PC wrap at the top of the address space.
        flush_req = 1'b1;
        flush_pc  = 32'hFFFF_FFF8;
        step("wrap_fl");
        flush_req = 1'b0;
        step("wrap_a");
        chk("wrap_top", 64'(pc), 64'hFFFF_FFFC);
        step("wrap_b");
        chk("wrap_zero", 64'(pc), 64'h0);

        // Randomized traffic with occasional long stall bursts.
        for (int i = 0; i < 400; i++) begin
            if (burst == 0 && $urandom_range(0, 30) == 0) burst = int'($urandom_range(3, 8));
            if (burst > 0) begin
                stallreq = 5'($urandom_range(1, 31));
                burst--;
            end else begin
                stallreq = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'b0;
            end
            flush_req = ($urandom_range(0, 15) == 0);
            halt_req  = ($urandom_range(0, 11) == 0);
            resume    = ($urandom_range(0, 3) == 0);
            cnt_clr   = ($urandom_range(0, 19) == 0);
            flush_pc  = 32'($urandom) & 32'hFFFF_FFFC;
            step("rnd");
        end

        // Reset asserted between edges while in FLUSH.
        stallreq  = '0;
        halt_req  = 1'b0;
        resume    = 1'b0;
        cnt_clr   = 1'b0;
        flush_req = 1'b1;
        flush_pc  = 32'h40;
        step("pre_rst_fl");
        flush_req = 1'b0;
        step("pre_rst_run");
        stallreq = 5'b00001;
        step("pre_rst_stall");
        step("pre_rst_stall");
        stallreq  = '0;
        flush_req = 1'b1;
        step("pre_rst_flush");
        flush_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        chk("mr_state", 64'(state), 64'd0);
        chk("mr_ce", 64'(ce), 64'd0);
        chk("mr_pc", 64'(pc), 64'(RESET_PC));
        chk("mr_flush", 64'(flush), 64'd0);
        chk("mr_hang", 64'(hang), 64'd0);
        chk("mr_cnt", 64'(stall_cnt), 64'd0);
        check_all("mid_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("post_rst");
        step("post_rst");
        step("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline controller for the five-stage core, replacing the fixed PC register and the ad-hoc per-stage stall wiring in the top level. It owns the fetch PC and the fetch enable for instruction ROM. It resolves per-stage stall requests into a stall/bubble vector, sequences flush and halt via a small state machine, and keeps stall statistics with a hang watchdog. It sits beside the pipeline registers, driving their stall and flush inputs and the instruction-memory address.

## Interface
Parameters:
- STAGES, 5, number of pipeline stages; bit 0 = IF, bit STAGES-1 = WB; minimum 2.
- PC_W, 32, PC width.
- RESET_PC, 0, PC value after reset.
- PC_INC, 4, PC increment per fetch.
- CNT_W, 32, stall statistics counter width.
- TIMEOUT, 1024, consecutive stalled cycles that raise hang; minimum 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- stallreq  in  STAGES  per-stage stall request.
- flush_req  in  1  flush request (exception/redirect).
- flush_pc  in  PC_W  redirect target, sampled with flush_req.
- halt_req  in  1  request to stop fetching.
- resume  in  1  leave HALT.
- cnt_clr  in  1  synchronous clear of stall_cnt.
- ce  out  1  instruction ROM enable, registered.
- pc  out  PC_W  fetch address, registered.
- stall  out  STAGES  per-stage hold, combinational.
- bubble  out  STAGES  per-stage NOP insertion, combinational.
- flush  out  1  clear all pipeline registers, registered (state decode).
- state  out  2  IDLE=0, RUN=1, FLUSH=2, HALT=3.
- stall_cnt  out  CNT_W  saturating count of stalled RUN cycles.
- hang  out  1  watchdog flag, registered.

## Operation
- Reset (async, immediate): state=IDLE, ce=0, pc=RESET_PC, stall_cnt=0, hang=0, internal run-length=0. Combinational outputs in IDLE: stall=0, bubble=0, flush=0.
- IDLE: next edge goes to RUN, ce=1, pc unchanged (first fetch at RESET_PC).
- RUN: let k = highest index with stallreq[k]=1.
  - stall[j]=1 for all j<=k, else 0.
  - bubble[k+1]=1 if k+1<STAGES, all other bubble bits 0.
  - No request: stall=0, bubble=0.
- RUN edge priority is flush_req > halt_req > stall.
  - flush_req: go to FLUSH, pc<=flush_pc.
  - halt_req: go to HALT, ce<=0, pc held.
  - else if stall[0]: pc held.
  - else: pc<=pc+PC_INC, modulo 2^PC_W (wraps, no flag).
- FLUSH, exactly one cycle unless re-requested:
  - flush=1, stall=0, bubble=0, ce=1, instruction at the redirected pc is fetched.
  - Next edge: flush_req again reloads pc<=flush_pc and stays in FLUSH. Else pc<=pc+PC_INC and go to RUN.
- HALT:
  - ce=0, stall=all ones, bubble=0; stallreq ignored.
  - flush_req: go to FLUSH, ce<=1, pc<=flush_pc.
  - Else resume: go to RUN, ce<=1, pc held.
  - halt_req and resume together while in HALT: resume wins.
- Statistics:
  - stall_cnt increments on each RUN edge where stallreq!=0. It saturates at 2^CNT_W-1.
  - cnt_clr sets stall_cnt<=0 and takes priority over increment.
- Watchdog:
  - The run-length counter increments on each RUN edge with stallreq!=0 and resets to 0 otherwise, including in FLUSH and HALT.
  - hang<=1 when run-length reaches TIMEOUT. The run-length saturates at TIMEOUT.
  - hang clears on the edge that enters FLUSH, or on the first RUN edge with stallreq==0.

## Timing
- stall/bubble: zero-latency combinational from stallreq and state; no combinational path from flush_req, halt_req or resume to any output.
- flush_req at edge N: flush=1 and pc=flush_pc during cycle N+1; pc=flush_pc+PC_INC after edge N+1.
- halt_req at edge N: ce=0 from N+1; resume at edge M: ce=1 from M+1, same pc re-fetched.
- Reset deassertion: first ce=1 one cycle after the first edge with rst=0.
- hang rises on the edge where the TIMEOUT-th consecutive stalled cycle completes.

## Test plan
- Reset release, STAGES=5, RESET_PC=0, no requests -> ce=0 for one cycle, then pc=0,4,8,12 on successive cycles, stall=0, bubble=0.
- stallreq=5'b00100 for 3 cycles -> stall=5'b00111, bubble=5'b01000, pc frozen 3 cycles, stall_cnt=3; stallreq=5'b00011 -> stall=5'b00011, bubble=5'b00100.
- flush_req with flush_pc=0x80 together with halt_req and stallreq=5'b00010 -> next cycle state=FLUSH, flush=1, stall=0, pc=0x80; then RUN with pc=0x84; back-to-back flush_req with flush_pc=0x100 -> FLUSH held, pc=0x100.
- halt_req -> HALT, ce=0, stall=5'b11111; resume asserted with halt_req -> RUN, same pc re-fetched; flush_req in HALT -> FLUSH.
- TIMEOUT=4, continuous stallreq=5'b10000 -> hang=1 after the 4th stalled edge; stallreq=0 -> hang=0. CNT_W=2 -> stall_cnt saturates at 3; cnt_clr -> 0. pc=0xFFFFFFFC increments -> 0.
- rst asserted mid-FLUSH, between edges -> outputs immediately at reset values (state=IDLE, ce=0, pc=RESET_PC, flush=0, hang=0, stall_cnt=0).
